pingpong_line_buffer: RTL and testbench

Parametrised N-bank line buffer: successor of the two-bank ping-pong RAM, used between the SC130GS capture path and downstream line-based filters in the 720P pipeline.
- Writer fills one bank per video line; committed lines are queued in order.
- Reader drains the oldest committed line while later banks continue filling.
- Adds explicit end-of-line marking, per-line length, backpressure, fill status and overflow reporting.

---
 rtl/pingpong_pkg.sv | 22 ++
 rtl/pp_bank_ram.sv | 35 +++
 rtl/pingpong_line_buffer.sv | 163 ++++++++++++++++
 tb/tb_pingpong_line_buffer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pingpong_pkg.sv
// Shared definitions for the N-bank ping-pong line buffer: bank life-cycle
// states, the maximum supported bank count and the ring-pointer increment.
package pingpong_pkg;

    // Life cycle of one bank: FREE -> FILLING -> READY -> DRAINING -> FREE
    typedef enum logic [1:0] {
        FREE     = 2'd0,
        FILLING  = 2'd1,
        READY    = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    localparam int MAX_BANKS = 8;

    // Advance a bank pointer around a ring of num_banks entries
    function automatic logic [2:0] ptr_inc(input logic [2:0] ptr, input int unsigned num_banks);
        logic [2:0] last;
        last = 3'(num_banks - 1);
        return (ptr == last) ? 3'd0 : ptr + 3'd1;
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// One line bank: simple dual-port RAM, one write port and one read port with
// a single registered read stage so it maps onto block RAM.
module pp_bank_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_reg [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    // Write port: contents survive reset, nothing here is cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read port: data appears one cycle after the enabled read
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem_reg[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/pingpong_line_buffer.sv
// N-bank line buffer. The writer fills the bank at the write pointer and
// commits it on wlast or when the bank is full; committed lines are drained
// in order from the read pointer. Banks form a ring, so commit order equals
// read order.
// Optional build macro PP_LINE_REPLAY_EN adds a replay input that keeps the
// head line resident after its last word is read, so it is emitted again.
module pingpong_line_buffer
    import pingpong_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_BANKS  = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           wlast,
    output logic                           wready,
    input  logic                           re,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           rvalid,
    output logic                           rlast,
    output logic                           line_avail,
    output logic [ADDR_WIDTH:0]            line_len,
    output logic [$clog2(NUM_BANKS+1)-1:0] lines_ready,
`ifdef PP_LINE_REPLAY_EN
    input  logic                           replay,
`endif
    output logic                           overflow
);

    localparam int PW = $clog2(NUM_BANKS);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(NUM_BANKS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    bank_state_e           bank_state_reg [NUM_BANKS];
    logic [LW-1:0]         bank_len_reg   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_q         [NUM_BANKS];

    logic [PW-1:0]         wptr_reg, rptr_reg, rd_bank_reg;
    logic [ADDR_WIDTH-1:0] waddr_reg, raddr_reg;
    logic [CW-1:0]         lines_ready_reg;
    logic                  overflow_reg, rvalid_reg, rlast_reg;

    logic          wr_acc, wr_commit, rd_acc, rd_last, rd_free;
    logic [LW-1:0] head_len;
    logic [PW-1:0] wptr_next, rptr_next;

    // Handshake and commit/free decode from the current bank states
    always_comb begin
        wready    = (bank_state_reg[wptr_reg] == FREE) || (bank_state_reg[wptr_reg] == FILLING);
        line_avail = (bank_state_reg[rptr_reg] == READY) || (bank_state_reg[rptr_reg] == DRAINING);
        head_len  = bank_len_reg[rptr_reg];
        wr_acc    = we && wready;
        wr_commit = wr_acc && (wlast || (waddr_reg == LAST_ADDR));
        rd_acc    = re && line_avail;
        rd_last   = ({1'b0, raddr_reg} == (head_len - LW'(1)));
`ifdef PP_LINE_REPLAY_EN
        rd_free   = rd_acc && rd_last && !replay;
`else
        rd_free   = rd_acc && rd_last;
`endif
        wptr_next = PW'(ptr_inc(3'(wptr_reg), NUM_BANKS));
        rptr_next = PW'(ptr_inc(3'(rptr_reg), NUM_BANKS));
    end

    // Bank storage: write and read bank are never the same bank
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            pp_bank_ram #(
                .DATA_WIDTH(DATA_WIDTH),
                .ADDR_WIDTH(ADDR_WIDTH)
            ) u_ram (
                .clk  (clk),
                .we   (wr_acc && (wptr_reg == PW'(gi))),
                .waddr(waddr_reg),
                .wdata(wdata),
                .re   (rd_acc && (rptr_reg == PW'(gi))),
                .raddr(raddr_reg),
                .rdata(bank_q[gi])
            );
        end
    endgenerate

    // Bank state machine, lengths and the write/read pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_state_reg[i] <= FREE;
                bank_len_reg[i]   <= '0;
            end
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            waddr_reg <= '0;
            raddr_reg <= '0;
        end else begin
            if (wr_acc) begin
                if (wr_commit) begin
                    bank_state_reg[wptr_reg] <= READY;
                    bank_len_reg[wptr_reg]   <= {1'b0, waddr_reg} + LW'(1);
                    waddr_reg                <= '0;
                    wptr_reg                 <= wptr_next;
                end else begin
                    bank_state_reg[wptr_reg] <= FILLING;
                    waddr_reg                <= waddr_reg + 1'b1;
                end
            end
            if (rd_acc) begin
                if (rd_last) begin
                    bank_state_reg[rptr_reg] <= rd_free ? FREE : READY;
                    raddr_reg                <= '0;
                    if (rd_free) begin
                        rptr_reg <= rptr_next;
                    end
                end else begin
                    bank_state_reg[rptr_reg] <= DRAINING;
                    raddr_reg                <= raddr_reg + 1'b1;
                end
            end
        end
    end

    // Committed-line count and sticky overflow on a dropped write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lines_ready_reg <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            case ({wr_commit, rd_free})
                2'b10:   lines_ready_reg <= lines_ready_reg + CW'(1);
                2'b01:   lines_ready_reg <= lines_ready_reg - CW'(1);
                default: lines_ready_reg <= lines_ready_reg;
            endcase
            if (we && !wready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Read-side flags registered alongside the RAM read stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rd_bank_reg <= '0;
        end else begin
            rvalid_reg  <= rd_acc;
            rlast_reg   <= rd_acc && rd_last;
            rd_bank_reg <= rptr_reg;
        end
    end

    // rdata is forced to zero when not valid so reset leaves it at 0
    assign rdata       = rvalid_reg ? bank_q[rd_bank_reg] : '0;
    assign rvalid      = rvalid_reg;
    assign rlast       = rlast_reg;
    assign line_len    = line_avail ? head_len : '0;
    assign lines_ready = lines_ready_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_pingpong_line_buffer.sv
// Self-checking bench for pingpong_line_buffer (default build, 2 banks,
// 16-word lines). The reference keeps committed lines as a FIFO of words
// plus a FIFO of line lengths; the buffer can hold at most NB lines.
module tb_pingpong_line_buffer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NB = 2;
    localparam int MAXLEN = 2**AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [DW-1:0] wdata;
    logic          wlast;
    logic          wready;
    logic          re;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rlast;
    logic          line_avail;
    logic [AW:0]   line_len;
    logic [1:0]    lines_ready;
    logic          overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DW-1:0] m_words[$];
    int            m_lens[$];
    logic [DW-1:0] m_part[$];
    int            m_rpos;
    bit            m_ovf;

    pingpong_line_buffer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_BANKS (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wdata      (wdata),
        .wlast      (wlast),
        .wready     (wready),
        .re         (re),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .line_avail (line_avail),
        .line_len   (line_len),
        .lines_ready(lines_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_words.delete();
        m_lens.delete();
        m_part.delete();
        m_rpos = 0;
        m_ovf  = 1'b0;
    endtask

    // Asserted between clock edges so the outputs must clear asynchronously
    task automatic do_reset();
        reset = 1'b0;
        we = 1'b0; wdata = '0; wlast = 1'b0; re = 1'b0;
        #1;
        chk("rst_wready",      32'(wready),      32'd1);
        chk("rst_line_avail",  32'(line_avail),  32'd0);
        chk("rst_line_len",    32'(line_len),    32'd0);
        chk("rst_lines_ready", 32'(lines_ready), 32'd0);
        chk("rst_overflow",    32'(overflow),    32'd0);
        chk("rst_rvalid",      32'(rvalid),      32'd0);
        chk("rst_rlast",       32'(rlast),       32'd0);
        chk("rst_rdata",       32'(rdata),       32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
    endtask

    // One clock cycle: drive, check status, update model, check read outputs
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit l, input bit r);
        bit            exp_wr, exp_av, wacc, racc, exp_last;
        int            exp_len;
        logic [DW-1:0] exp_d;
        we = w; wdata = d; wlast = l; re = r;
        #1;
        exp_wr  = (m_lens.size() < NB);
        exp_av  = (m_lens.size() > 0);
        exp_len = exp_av ? m_lens[0] : 0;
        chk("wready",      32'(wready),      32'(exp_wr));
        chk("line_avail",  32'(line_avail),  32'(exp_av));
        chk("line_len",    32'(line_len),    32'(exp_len));
        chk("lines_ready", 32'(lines_ready), 32'(m_lens.size()));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        wacc = w && exp_wr;
        racc = r && exp_av;
        exp_d = '0;
        exp_last = 1'b0;
        if (racc) begin
            exp_d    = m_words.pop_front();
            exp_last = (m_rpos == m_lens[0] - 1);
            if (exp_last) begin
                void'(m_lens.pop_front());
                m_rpos = 0;
            end else begin
                m_rpos++;
            end
        end
        if (w && !exp_wr) m_ovf = 1'b1;
        if (wacc) begin
            m_part.push_back(d);
            if (l || m_part.size() == MAXLEN) begin
                m_lens.push_back(m_part.size());
                foreach (m_part[k]) m_words.push_back(m_part[k]);
                m_part.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("rvalid", 32'(rvalid), 32'(racc));
        chk("rlast",  32'(rlast),  32'(exp_last));
        if (racc) chk("rdata", 32'(rdata), 32'(exp_d));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        we = 1'b0; wdata = '0; wlast = 1'b0; re = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single 8-word line written then read back
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), i == 7, 1'b0);
        chk("t1_len8", 32'(line_len), 32'd8);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_avail_after", 32'(line_avail), 32'd0);

        // Fill both banks, then a dropped write of 0x55
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), (i == 7) || (i == 15), 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        chk("t2_wready",      32'(wready),      32'd0);
        chk("t2_overflow",    32'(overflow),    32'd1);
        chk("t2_lines_ready", 32'(lines_ready), 32'd2);
        for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Full-length line commits without wlast; next line uses the other bank
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        chk("t3_len16", 32'(line_len), 32'd16);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), i == 3, 1'b0);
        chk("t3_lines_ready", 32'(lines_ready), 32'd2);
        for (int i = 0; i < 21; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Drain line A while line B fills; B commits as A frees its bank
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hA0 + i), i == 7, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hB0 + i), i == 7, 1'b1);
        chk("t4_lines_ready", 32'(lines_ready), 32'd1);
        chk("t4_len", 32'(line_len), 32'd8);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-line discards the partial line
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hD0 + i), i == 2, 1'b0);
        chk("t5_len3", 32'(line_len), 32'd3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom % 3) != 0, 8'($urandom), ($urandom % 6) == 0, ($urandom % 2) == 1);
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
